// File: rtl/lcd_pkg.sv
// Shared types and constants for the 4-bit character-LCD bus sequencer.
// Timing defaults are clock-cycle counts; the instruction word is {RS, RW, D7..D0}.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPwrWait,
        StNibSetup,
        StNibEn,
        StNibHold,
        StInitWait,
        StIdle,
        StGap,
        StCmdWait
    } state_e;

    // Selects where a finished nibble goes: init wait, inter-nibble gap or command wait.
    typedef enum logic [1:0] {
        PhInit,
        PhUpper,
        PhLower
    } phase_e;

    localparam int unsigned DEF_T_SETUP = 2;
    localparam int unsigned DEF_T_EN    = 12;
    localparam int unsigned DEF_T_HOLD  = 1;
    localparam int unsigned DEF_T_GAP   = 50;
    localparam int unsigned DEF_T_CMD   = 2000;
    localparam int unsigned DEF_T_PWR   = 750000;
    localparam int unsigned DEF_T_INIT1 = 205000;
    localparam int unsigned DEF_T_INIT2 = 5000;
    localparam int unsigned DEF_CW      = 20;

    localparam int unsigned INSTR_W   = 10;
    localparam int unsigned INSTR_RS  = 9;
    localparam int unsigned INSTR_RW  = 8;
    localparam int unsigned DATA_MSB  = 7;
    localparam int unsigned DATA_LSB  = 0;

    localparam logic [1:0] INIT_LAST_STEP = 2'd3;

    function automatic logic [3:0] init_nibble(input logic [1:0] step);
        return (step == INIT_LAST_STEP) ? 4'h2 : 4'h3;
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that times every sequencer state.
// Saturates at zero so an idle state simply sits expired.
module lcd_delay_counter #(
    parameter int unsigned CW      = 20,
    parameter int unsigned RST_VAL = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_expired
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= CW'(RST_VAL);
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Drives the 4-bit LCD bus: autonomous power-on nibble init, then two-nibble
// instruction writes launched by a start/done handshake.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_EN    = DEF_T_EN,
    parameter int unsigned T_HOLD  = DEF_T_HOLD,
    parameter int unsigned T_GAP   = DEF_T_GAP,
    parameter int unsigned T_CMD   = DEF_T_CMD,
    parameter int unsigned T_PWR   = DEF_T_PWR,
    parameter int unsigned T_INIT1 = DEF_T_INIT1,
    parameter int unsigned T_INIT2 = DEF_T_INIT2,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_init_done,
    output logic               o_lcd_e,
    output logic               o_lcd_rs,
    output logic               o_lcd_rw,
    output logic [3:0]         o_lcd_d
);

    state_e        r_state, w_state_d;
    phase_e        r_phase, w_phase_d;
    logic [1:0]    r_step, w_step_d;
    logic [3:0]    r_lcd_d, w_lcd_d_d;
    logic          r_lcd_rs, w_lcd_rs_d;
    logic [3:0]    r_lo_nib, w_lo_nib_d;
    logic          r_done, w_done_d;
    logic          r_init_done, w_init_done_d;

    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic [CW-1:0] w_init_wait;
    logic          w_expired;
    logic          w_unused_rw;

    // Write-only bus: the RW bit of the instruction word has no effect.
    assign w_unused_rw = i_instr[INSTR_RW];

    lcd_delay_counter #(
        .CW      (CW),
        .RST_VAL (T_PWR - 1)
    ) u_delay (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (1'b1),
        .o_expired  (w_expired)
    );

    always_comb begin
        unique case (r_step)
            2'd0:    w_init_wait = CW'(T_INIT1 - 1);
            2'd1:    w_init_wait = CW'(T_INIT2 - 1);
            default: w_init_wait = CW'(T_CMD - 1);
        endcase
    end

    always_comb begin
        w_state_d     = r_state;
        w_phase_d     = r_phase;
        w_step_d      = r_step;
        w_lcd_d_d     = r_lcd_d;
        w_lcd_rs_d    = r_lcd_rs;
        w_lo_nib_d    = r_lo_nib;
        w_done_d      = 1'b0;
        w_init_done_d = r_init_done;
        w_load        = 1'b0;
        w_load_val    = '0;

        unique case (r_state)
            StPwrWait: begin
                if (w_expired) begin
                    w_state_d  = StNibSetup;
                    w_phase_d  = PhInit;
                    w_step_d   = 2'd0;
                    w_lcd_d_d  = init_nibble(2'd0);
                    w_lcd_rs_d = 1'b0;
                    w_load     = 1'b1;
                    w_load_val = CW'(T_SETUP - 1);
                end
            end
            StNibSetup: begin
                if (w_expired) begin
                    w_state_d  = StNibEn;
                    w_load     = 1'b1;
                    w_load_val = CW'(T_EN - 1);
                end
            end
            StNibEn: begin
                if (w_expired) begin
                    w_state_d  = StNibHold;
                    w_load     = 1'b1;
                    w_load_val = CW'(T_HOLD - 1);
                end
            end
            StNibHold: begin
                if (w_expired) begin
                    w_load = 1'b1;
                    unique case (r_phase)
                        PhInit: begin
                            w_state_d  = StInitWait;
                            w_load_val = w_init_wait;
                        end
                        PhUpper: begin
                            w_state_d  = StGap;
                            w_load_val = CW'(T_GAP - 1);
                        end
                        default: begin
                            w_state_d  = StCmdWait;
                            w_load_val = CW'(T_CMD - 1);
                        end
                    endcase
                end
            end
            StInitWait: begin
                if (w_expired) begin
                    if (r_step == INIT_LAST_STEP) begin
                        w_state_d     = StIdle;
                        w_init_done_d = 1'b1;
                    end else begin
                        w_state_d  = StNibSetup;
                        w_step_d   = r_step + 2'd1;
                        w_lcd_d_d  = init_nibble(r_step + 2'd1);
                        w_load     = 1'b1;
                        w_load_val = CW'(T_SETUP - 1);
                    end
                end
            end
            StIdle: begin
                if (i_start) begin
                    w_state_d  = StNibSetup;
                    w_phase_d  = PhUpper;
                    w_lcd_d_d  = i_instr[DATA_MSB -: 4];
                    w_lcd_rs_d = i_instr[INSTR_RS];
                    w_lo_nib_d = i_instr[DATA_LSB +: 4];
                    w_load     = 1'b1;
                    w_load_val = CW'(T_SETUP - 1);
                end
            end
            StGap: begin
                if (w_expired) begin
                    w_state_d  = StNibSetup;
                    w_phase_d  = PhLower;
                    w_lcd_d_d  = r_lo_nib;
                    w_load     = 1'b1;
                    w_load_val = CW'(T_SETUP - 1);
                end
            end
            StCmdWait: begin
                if (w_expired) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= StPwrWait;
            r_phase     <= PhInit;
            r_step      <= 2'd0;
            r_lcd_d     <= 4'h0;
            r_lcd_rs    <= 1'b0;
            r_lo_nib    <= 4'h0;
            r_done      <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_phase     <= w_phase_d;
            r_step      <= w_step_d;
            r_lcd_d     <= w_lcd_d_d;
            r_lcd_rs    <= w_lcd_rs_d;
            r_lo_nib    <= w_lo_nib_d;
            r_done      <= w_done_d;
            r_init_done <= w_init_done_d;
        end
    end

    // E decodes straight from the state register so reset drops it without waiting for a clock.
    assign o_lcd_e     = (r_state == StNibEn);
    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
    assign o_init_done = r_init_done;
    assign o_lcd_rs    = r_lcd_rs;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_d     = r_lcd_d;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Randomised bench: a cycle-by-cycle expected bus timeline is built from the
// LCD timing rules and compared with the sequencer outputs.
module tb_lcd_bus_sequencer;

    localparam int unsigned TS = 1, TE = 2, TH = 1, TG = 3, TC = 4;
    localparam int unsigned TP = 10, TI1 = 6, TI2 = 5;
    localparam int unsigned L  = 2 * (TS + TE + TH) + TG + TC;

    // {e, rs, rw, d[3:0], busy, done, init_done}
    localparam logic [9:0] RESET_V = 10'b0_0_0_0000_1_0_0;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] instr = '0;
    logic       done, busy, init_done, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_d;

    lcd_bus_sequencer #(
        .T_SETUP (TS), .T_EN (TE), .T_HOLD (TH), .T_GAP (TG), .T_CMD (TC),
        .T_PWR (TP), .T_INIT1 (TI1), .T_INIT2 (TI2), .CW (20)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset_n),
        .i_start     (start),
        .i_instr     (instr),
        .o_done      (done),
        .o_busy      (busy),
        .o_init_done (init_done),
        .o_lcd_e     (lcd_e),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_d     (lcd_d)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic [3:0] d;
        logic       init;
        logic       fin;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_d = '0;
    logic       m_rs = 1'b0;
    logic       pend = 1'b0;
    logic       in_reset = 1'b1;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [9:0] observed();
        return {lcd_e, lcd_rs, lcd_rw, lcd_d, busy, done, init_done};
    endfunction

    task automatic push(input logic e, input logic rs, input logic [3:0] d,
                        input logic init, input int n, input logic fin_last);
        ent_t x;
        for (int i = 0; i < n; i++) begin
            x.e = e; x.rs = rs; x.d = d; x.init = init;
            x.fin = fin_last && (i == n - 1);
            q.push_back(x);
        end
    endtask

    task automatic push_nibble(input logic [3:0] d, input logic rs, input logic init);
        push(1'b0, rs, d, init, TS, 1'b0);
        push(1'b1, rs, d, init, TE, 1'b0);
        push(1'b0, rs, d, init, TH, 1'b0);
    endtask

    task automatic push_init();
        int         waits [4];
        logic [3:0] nibs  [4];
        waits = '{TI1, TI2, TC, TC};
        nibs  = '{4'h3, 4'h3, 4'h3, 4'h2};
        // Release happens mid-way through the first power-wait cycle.
        push(1'b0, 1'b0, 4'h0, 1'b0, TP - 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_nibble(nibs[i], 1'b0, 1'b0);
            push(1'b0, 1'b0, nibs[i], 1'b0, waits[i], 1'b0);
        end
    endtask

    task automatic push_xfer(input logic [9:0] ins);
        push_nibble(ins[7:4], ins[9], 1'b1);
        push(1'b0, ins[9], ins[7:4], 1'b1, TG, 1'b0);
        push_nibble(ins[3:0], ins[9], 1'b1);
        push(1'b0, ins[9], ins[3:0], 1'b1, TC, 1'b1);
    endtask

    // Compare one cycle at the falling edge, then drive the inputs for the next rising edge.
    task automatic cycle(input logic st, input logic [9:0] ins);
        ent_t       x;
        logic [9:0] exp_v;
        logic       idle;
        @(negedge clk);
        idle = 1'b0;
        if (in_reset) begin
            exp_v = RESET_V;
        end else if (q.size() > 0) begin
            x     = q.pop_front();
            exp_v = {x.e, x.rs, 1'b0, x.d, 1'b1, 1'b0, x.init};
            m_d   = x.d;
            m_rs  = x.rs;
            if (x.fin) pend = 1'b1;
        end else begin
            exp_v = {1'b0, m_rs, 1'b0, m_d, 1'b0, pend, 1'b1};
            pend  = 1'b0;
            idle  = 1'b1;
        end
        check("bus", {6'h0, observed()}, {6'h0, exp_v});
        start = st;
        instr = ins;
        if (idle && st) push_xfer(ins);
    endtask

    task automatic release_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0);
        reset_n  = 1'b1;
        in_reset = 1'b0;
        push_init();
    endtask

    task automatic async_reset();
        #1;
        reset_n  = 1'b0;
        in_reset = 1'b1;
        q.delete();
        pend = 1'b0;
        m_d  = '0;
        m_rs = 1'b0;
        #1;
        check("rst_async", {6'h0, observed()}, {6'h0, RESET_V});
        release_reset();
    endtask

    task automatic drain();
        while (q.size() > 0 || pend) cycle(1'b0, '0);
    endtask

    task automatic run_random(input int n);
        logic hold;
        hold = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i % 150 == 0) hold = ($urandom_range(0, 2) == 0);
            cycle(hold ? 1'b1 : ($urandom_range(0, 5) == 0), 10'($urandom));
        end
    endtask

    task automatic latency_test(input logic [9:0] ins, input string tag);
        int lat;
        drain();
        cycle(1'b1, ins);
        lat = 0;
        for (int i = 1; i <= 4 * L; i++) begin
            cycle(1'b0, '0);
            if (done) begin
                lat = i;
                break;
            end
        end
        check(tag, 16'(lat), 16'(L + 1));
    endtask

    initial begin
        // Reset state, then init with random starts that must be ignored.
        release_reset();
        for (int i = 0; i < 80; i++) cycle(i == 3 || ($urandom_range(0, 3) == 0), 10'($urandom));
        drain();
        check("init_done", {15'h0, init_done}, 16'h1);

        latency_test(10'b10_0100_1000, "lat_H");
        latency_test(10'b01_0000_0001, "lat_rw");

        // Start held high across a transfer: back-to-back start in the done cycle.
        drain();
        for (int i = 0; i < 3 * L; i++) cycle(1'b1, 10'h2A5);
        run_random(1500);

        // Reset in the first enable cycle of the lower nibble.
        drain();
        cycle(1'b1, 10'h1C3);
        for (int i = 0; i < int'(TS + TE + TH + TG + TS + 1); i++) cycle(1'b0, '0);
        check("lower_en", {15'h0, lcd_e}, 16'h1);
        async_reset();
        for (int i = 0; i < 80; i++) cycle(1'b0, '0);
        run_random(1500);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
Drives the 4-bit character-LCD bus (E, RS, RW, D[3:0]) from 10-bit instruction words {RS,RW,D7..D0} issued by the configuration FSM with a start/done handshake.
Performs the mandatory power-on nibble initialisation autonomously after reset.
For each instruction it sends the upper nibble, then the lower nibble, with the LCD setup, enable-pulse, hold, inter-nibble and execution timings generated from clock-cycle counts.
Sits between the configuration FSM (which supplies db/next_instruction and consumes done) and the LCD pins.

Parameters:
T_SETUP, 2, cycles D/RS are stable before E rises (>=40 ns)
T_EN, 12, cycles E stays high (>=230 ns)
T_HOLD, 1, cycles D/RS are held after E falls (>=10 ns)
T_GAP, 50, cycles between the upper and lower nibble (>=1 us)
T_CMD, 2000, cycles of execution wait after the lower nibble (>=40 us)
T_PWR, 750000, cycles of power-on wait (>=15 ms)
T_INIT1, 205000, wait after init nibble 0 (>=4.1 ms)
T_INIT2, 5000, wait after init nibble 1 (>=100 us)
CW, 20, width of the delay counter; must hold max(T_*)

Ports:
clk  in  1  system clock, all logic on the rising edge
reset  in  1  asynchronous, active-low reset: 0 = reset
start  in  1  one-cycle pulse; launches the transfer of instr
instr  in  10  {RS, RW, D7..D0}; sampled at the start edge
done  out  1  one-cycle pulse when an instruction's T_CMD wait expires
busy  out  1  high while the init sequence or a transfer is in progress
init_done  out  1  high once the power-on sequence completes; stays high until reset
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; always 0 (write-only)
lcd_d  out  4  LCD data nibble

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to PWR_WAIT; counter loads T_PWR-1; init step = 0.
  - All outputs are 0 except busy=1.
- States: PWR_WAIT, NIB_SETUP, NIB_EN, NIB_HOLD, INIT_WAIT, IDLE, GAP, CMD_WAIT.
- Nibble sub-sequence (shared by init and write phases):
  - NIB_SETUP: T_SETUP cycles, E=0, D/RS driven.
  - NIB_EN: T_EN cycles, E=1.
  - NIB_HOLD: T_HOLD cycles, E=0, D/RS still driven.
  - An internal phase flag selects the exit: INIT_WAIT, GAP, or CMD_WAIT.
- Delay counter: loaded with T-1 on state entry, decrements each cycle; the state exits on the cycle the count reaches 0.
- Init sequence:
  - PWR_WAIT is followed by four nibbles with RS=0: 0x3, 0x3, 0x3, 0x2.
  - The waits after each nibble are T_INIT1, T_INIT2, T_CMD and T_CMD.
  - After the last wait: init_done=1, busy=0, state IDLE.
  - done is never pulsed during init.
- IDLE:
  - lcd_e=0; lcd_d and lcd_rs hold their last values.
  - When start=1, instr is latched; at the next edge the state is NIB_SETUP with lcd_d=instr[7:4] and lcd_rs=instr[9]; busy=1 from that edge.
- After the upper nibble's NIB_HOLD:
  - GAP lasts T_GAP cycles.
  - Then the lower-nibble sequence runs with lcd_d=instr[3:0].
  - Then CMD_WAIT lasts T_CMD cycles.
- Exit from CMD_WAIT: done=1 for one cycle, busy=0 in the same cycle, state IDLE. start is accepted again in that same cycle.
- Latency: L = 2*(T_SETUP+T_EN+T_HOLD) + T_GAP + T_CMD cycles.
  - With start sampled at edge k, done is high in the cycle after edge k+L+1.
- Boundary conditions:
  - start while busy=1 or init_done=0: ignored; no queueing and no error flag.
  - instr[8] (RW) is ignored; lcd_rw is constant 0.
  - Reset during any state aborts immediately to the reset values, E falls asynchronously, and the full init sequence re-runs.
  - Clear/Home commands need >=1.64 ms; that extra wait remains the caller's responsibility.

Decomposition:
- Package lcd_pkg:
  - state encoding localparams;
  - default timing constants;
  - init nibble values;
  - instruction field positions (RS=9, RW=8, DATA=7:0).
- One natural sub-module: lcd_delay_counter (load value, load strobe, decrement, expired flag, width CW).

Test Plan:
Bench overrides: T_SETUP=1, T_EN=2, T_HOLD=1, T_GAP=3, T_CMD=4, T_PWR=10, T_INIT1=6, T_INIT2=5 (so L=15).
1. Release reset -> 10 idle cycles, then E pulses with lcd_d 3,3,3,2 and RS=0; E-low gaps of 6/5/4/4 cycles between pulses; init_done rises; done stays 0.
2. After init, start with instr=10'b10_0100_1000 ('H' data write) -> E pulses with lcd_d=4 then 8, RS=1, RW=0; busy high; single done pulse 15 cycles (L) after the edge following the start edge.
3. Assert start on every cycle during a transfer -> exactly one transfer and one done; back-to-back start in the done cycle is accepted.
4. Start before init_done (for example at cycle 3) -> ignored; init completes unchanged; no done pulse.
5. Drive reset=0 mid-NIB_EN of the lower nibble -> lcd_e=0 and busy=1 immediately; after release the full init sequence re-runs; no done pulse.
6. instr=10'b01_0000_0001 (RW=1) -> lcd_rw stays 0; lcd_d sequence 0 then 1; done after L.
